// File: rtl/vx_commit_gather.sv
// Gathers NUM_INPUTS result streams into one commit stream: round-robin with per-packet lock, 2-entry registered output buffer.
// Optional per-input stall counters are compiled in when COMMIT_GATHER_PERF_EN is defined.
module vx_commit_gather #(
    parameter int NUM_INPUTS    = 4,
    parameter int DATAW         = 128,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_INPUTS-1:0]                in_valid,
    output logic [NUM_INPUTS-1:0]                in_ready,
    input  logic [NUM_INPUTS-1:0][DATAW-1:0]     in_data,
    input  logic [NUM_INPUTS-1:0]                in_sop,
    input  logic [NUM_INPUTS-1:0]                in_eop,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATAW-1:0]                     out_data,
    output logic                                 out_sop,
    output logic                                 out_eop
`ifdef COMMIT_GATHER_PERF_EN
    ,
    output logic [NUM_INPUTS-1:0][PERF_CTR_BITS-1:0] perf_stalls
`endif
);

    localparam int PW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [DATAW-1:0] data;
    } beat_t;

    logic [PW-1:0]         ptr_q, ptr_d, lock_idx_q, lock_idx_d;
    logic                  locked_q, locked_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d, rd_q, rd_d;
    beat_t [1:0]           buf_q, buf_d;
    logic [NUM_INPUTS-1:0] grant;
    logic [PW-1:0]         sel;
    logic                  sel_vld, full, push, pop;

    // While locked only the owner may be granted, even if it is idle, so packets never interleave.
    always_comb begin
        grant   = '0;
        sel     = '0;
        sel_vld = 1'b0;
        if (locked_q) begin
            sel     = lock_idx_q;
            sel_vld = in_valid[lock_idx_q];
        end else begin
            // Scan backwards so the candidate closest to the pointer is written last and wins.
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                if (in_valid[(int'(ptr_q) + k) % NUM_INPUTS]) begin
                    sel     = PW'((int'(ptr_q) + k) % NUM_INPUTS);
                    sel_vld = 1'b1;
                end
            end
        end
        if (sel_vld) grant[sel] = 1'b1;
    end

    assign full     = (cnt_q == 2'd2);
    assign in_ready = grant & {NUM_INPUTS{~full & reset}};
    assign push     = |in_ready;
    assign pop      = out_valid & out_ready;

    always_comb begin
        ptr_d      = ptr_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (push) begin
            if (in_eop[sel]) begin
                locked_d = 1'b0;
                ptr_d    = (sel == PW'(NUM_INPUTS - 1)) ? '0 : sel + PW'(1);
            end else begin
                locked_d   = 1'b1;
                lock_idx_d = sel;
            end
        end
    end

    always_comb begin
        buf_d = buf_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            buf_d[wr_q] = '{sop: in_sop[sel], eop: in_eop[sel], data: in_data[sel]};
            wr_d        = ~wr_q;
        end
        if (pop) rd_d = ~rd_q;
        cnt_d = cnt_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            buf_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            buf_q      <= buf_d;
        end
    end

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = buf_q[rd_q].data;
    assign out_sop   = buf_q[rd_q].sop;
    assign out_eop   = buf_q[rd_q].eop;

`ifdef COMMIT_GATHER_PERF_EN
    logic [NUM_INPUTS-1:0][PERF_CTR_BITS-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        for (int i = 0; i < NUM_INPUTS; i++)
            stall_d[i] = stall_q[i] + PERF_CTR_BITS'(in_valid[i] & ~in_ready[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign perf_stalls = stall_q;
`endif

endmodule
